// File: rtl/ahb_slave_mem.sv
// AHB-Lite word memory slave: WAIT_STATES cycles with HREADYOUT low, then OKAY; bad transfers get a two-cycle ERROR.
// Define AHB_SLV_ALIGN_CHECK_EN to treat misaligned half/word transfers as bad instead of silently aligning them.
module ahb_slave_mem #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [7:0]  err_count
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WS_CNT  = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    be_q, be_d;
  logic          wr_q, wr_d;
  logic          hready_q, hready_d;
  logic [1:0]    hresp_q, hresp_d;
  logic [7:0]    err_count_q, err_count_d;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   offset;
  logic          accept;
  logic          bad;
  logic          misaligned;
  logic [3:0]    be_new;
  logic          unused_sig;

  always_comb begin
    offset     = HADDR - BASE_ADDR;
    misaligned = (HSIZE == 3'b001 && HADDR[0]) || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);
    bad        = (HADDR < BASE_ADDR) || ({2'b00, offset[31:2]} >= DEPTH_W) || (HSIZE > 3'b010);
`ifdef AHB_SLV_ALIGN_CHECK_EN
    bad        = bad || misaligned;
`endif
    // Lane enables ignore the low address bits that a misaligned access would otherwise imply.
    case (HSIZE)
      3'b000:  be_new = 4'b0001 << HADDR[1:0];
      3'b001:  be_new = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_new = 4'b1111;
    endcase
    // Only states that drive HREADYOUT high can take a new address phase.
    accept = HSEL && HREADYIN && HTRANS[1] && hready_q;
  end

`ifdef AHB_SLV_ALIGN_CHECK_EN
  assign unused_sig = ^{HBURST, HTRANS[0], offset[1:0]};
`else
  assign unused_sig = ^{HBURST, HTRANS[0], offset[1:0], misaligned};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    be_d        = be_q;
    wr_d        = wr_q;
    hready_d    = 1'b1;
    hresp_d     = 2'b00;
    err_count_d = err_count_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          hready_d = 1'b0;
        end
      end
      S_ERR1: begin
        state_d     = S_ERR2;
        hresp_d     = 2'b01;
        err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (bad) begin
            state_d  = S_ERR1;
            hready_d = 1'b0;
            hresp_d  = 2'b01;
          end else begin
            idx_d = offset[AW+1:2];
            be_d  = be_new;
            wr_d  = HWRITE;
            if (WS_CNT == 4'd0) begin
              state_d = S_DONE;
            end else begin
              state_d  = S_WAIT;
              cnt_d    = WS_CNT;
              hready_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      be_q        <= 4'd0;
      wr_q        <= 1'b0;
      hready_q    <= 1'b1;
      hresp_q     <= 2'b00;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      be_q        <= be_d;
      wr_q        <= wr_d;
      hready_q    <= hready_d;
      hresp_q     <= hresp_d;
      err_count_q <= err_count_d;
    end
  end

  // Commit on the edge closing DONE; a reset before then leaves the state IDLE and drops the write.
  always_ff @(posedge HCLK) begin
    if (state_q == S_DONE && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Read data comes straight from the array so a write committed on the same edge is visible.
  assign HRDATA    = (state_q == S_DONE && !wr_q) ? mem[idx_q] : 32'd0;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign err_count = err_count_q;

endmodule
